wb_host_master: RTL

// Wishbone classic initiator driving the user-project slave port (cyc/stb/we/sel/adr/dat -> ack/dat).

---
 rtl/wb_host_master.sv | 102 ++++++++++
 1 files changed

// File: rtl/wb_host_master.sv
// Wishbone classic single-cycle initiator with valid/ready command and response channels.
// One transaction in flight; a stalled slave is abandoned after TIMEOUT strobe cycles.
module wb_host_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_err_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic            wbm_ack_i,
    input  logic [DW-1:0]   wbm_dat_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    assign cmd_ready_o = (state == IDLE) && wb_rst_n_i;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state       <= IDLE;
            cnt         <= '0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        wbm_we_o  <= cmd_we_i;
                        wbm_adr_o <= cmd_adr_i;
                        wbm_dat_o <= cmd_dat_i;
                        wbm_sel_o <= cmd_sel_i;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        cnt       <= '0;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    // An ack on the final permitted cycle still counts as success.
                    if (wbm_ack_i) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_dat_o   <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
